// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the k-NN pass sequencer.
//   state_t  : sequencer states, 3-bit encoding (IDLE/CLR/RUN/READ/DONE)
//   KNN_ID_W : width of the datap_id carried to and from the k-NN list
package knn_ctrl_pkg;

    localparam int KNN_ID_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/knn_ctrl_credit_cnt.sv
// Request/response bookkeeping for one k-NN pass.
// Counts issued distance requests and received responses, and derives from
// them whether another request may be issued and whether every requested
// distance has come back.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart both counters for a new pass
//   issue      : a request is issued this cycle
//   recv       : a response is accepted this cycle
//   n_datap    : training points in the current pass (latched copy)
//   iss_cnt    : requests issued so far (also the next request address)
//   rcv_cnt    : responses accepted so far (also the next insert id)
//   can_issue  : points remain and the in-flight limit is not reached
//   has_out    : at least one request is awaiting its response
//   all_rcvd   : every point of the pass has been received
module knn_ctrl_credit_cnt #(
    parameter int ADDR_W  = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic              recv,
    input  logic [ADDR_W-1:0] n_datap,
    output logic [ADDR_W-1:0] iss_cnt,
    output logic [ADDR_W-1:0] rcv_cnt,
    output logic              can_issue,
    output logic              has_out,
    output logic              all_rcvd
);

    localparam logic [ADDR_W-1:0] MAX_OUT_V = ADDR_W'(MAX_OUT);

    logic [ADDR_W-1:0] out_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            iss_cnt <= '0;
            rcv_cnt <= '0;
        end else begin
            if (issue) begin
                iss_cnt <= iss_cnt + ADDR_W'(1);
            end
            if (recv) begin
                rcv_cnt <= rcv_cnt + ADDR_W'(1);
            end
        end
    end

    // Responses return in request order, so the in-flight count is simply
    // the difference; a same-cycle issue and receive leave it unchanged.
    assign out_cnt   = iss_cnt - rcv_cnt;
    assign can_issue = (iss_cnt < n_datap) && (out_cnt < MAX_OUT_V);
    assign has_out   = (out_cnt != '0);
    assign all_rcvd  = (rcv_cnt == n_datap);

endmodule

// File: rtl/knn_ctrl.sv
// Sequencer for one k-NN classification pass.
// On start it clears the k-NN list, streams n_datap training-point addresses
// to the distance unit (at most MAX_OUT in flight), forwards each returned
// distance tagged with its datap_id into the list, then reads the NBR_KNN
// stored ids back out one per cycle and pulses done.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start, n_datap          : begin a pass (IDLE only); point count latched
//   busy, done              : pass in progress; one-cycle end-of-pass pulse
//   tr_rd_en, tr_rd_addr    : distance request to the distance unit
//   dist_valid, dist_in     : in-order distance results
//   list_rst                : one-cycle k-NN list clear
//   list_valid/id/dist      : insert strobe and entry to the k-NN list
//   list_sel, list_info     : list readout slot and its (combinational) id
//   res_valid/idx/id        : registered readout results
// Optional feature: define KNN_CTRL_PERF_EN to add perf_cyc[31:0], the
// start-to-done cycle count (inclusive), cleared on start, saturating.
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int NBR_KNN = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          n_datap,
    output logic                       busy,
    output logic                       done,
    output logic                       tr_rd_en,
    output logic [ADDR_W-1:0]          tr_rd_addr,
    input  logic                       dist_valid,
    input  logic [DATA_W-1:0]          dist_in,
    output logic                       list_rst,
    output logic                       list_valid,
    output logic [KNN_ID_W-1:0]        list_id,
    output logic [DATA_W-1:0]          list_dist,
    output logic [$clog2(NBR_KNN)-1:0] list_sel,
    input  logic [KNN_ID_W-1:0]        list_info,
    output logic                       res_valid,
    output logic [$clog2(NBR_KNN)-1:0] res_idx,
    output logic [KNN_ID_W-1:0]        res_id
`ifdef KNN_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_cyc
`endif
);

    localparam int SEL_W = $clog2(NBR_KNN);
    // The readout counter must reach NBR_KNN itself: one extra READ cycle
    // lets the last registered result appear before DONE.
    localparam int RD_W = $clog2(NBR_KNN + 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(NBR_KNN);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] n_lat;
    logic [RD_W-1:0]   rd_cnt;
    logic [ADDR_W-1:0] iss_cnt;
    logic [ADDR_W-1:0] rcv_cnt;
    logic              can_issue;
    logic              has_out;
    logic              all_rcvd;
    logic              issue;
    logic              recv;
    logic              rd_capture;

    knn_ctrl_credit_cnt #(
        .ADDR_W  (ADDR_W),
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == CLR),
        .issue     (issue),
        .recv      (recv),
        .n_datap   (n_lat),
        .iss_cnt   (iss_cnt),
        .rcv_cnt   (rcv_cnt),
        .can_issue (can_issue),
        .has_out   (has_out),
        .all_rcvd  (all_rcvd)
    );

    assign rd_capture = (state == READ) && (rd_cnt < RD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat <= '0;
        end else if ((state == IDLE) && start) begin
            n_lat <= n_datap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (state == READ) begin
            rd_cnt <= rd_cnt + RD_W'(1);
        end else begin
            rd_cnt <= '0;
        end
    end

    // list_info is combinational on list_sel, so the id read in slot r is
    // registered here and presented one cycle later together with r.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_id    <= '0;
        end else begin
            res_valid <= rd_capture;
            res_idx   <= rd_capture ? rd_cnt[SEL_W-1:0] : '0;
            res_id    <= rd_capture ? list_info : '0;
        end
    end

`ifdef KNN_CTRL_PERF_EN
    // The start cycle itself counts as 1; every non-IDLE cycle through DONE
    // adds one, after which the value holds until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cyc <= '0;
        end else if ((state == IDLE) && start) begin
            perf_cyc <= 32'd1;
        end else if ((state != IDLE) && (perf_cyc != '1)) begin
            perf_cyc <= perf_cyc + 32'd1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        list_rst   = 1'b0;
        tr_rd_en   = 1'b0;
        tr_rd_addr = '0;
        list_valid = 1'b0;
        list_id    = '0;
        list_dist  = '0;
        list_sel   = '0;
        issue      = 1'b0;
        recv       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                busy      = 1'b1;
                list_rst  = 1'b1;
                state_nxt = (n_lat == '0) ? DONE : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                issue      = can_issue;
                tr_rd_en   = can_issue;
                tr_rd_addr = can_issue ? iss_cnt : '0;
                // A response with nothing in flight is a protocol error and
                // is dropped rather than inserted.
                recv       = dist_valid && has_out;
                list_valid = recv;
                list_id    = recv ? KNN_ID_W'(rcv_cnt) : '0;
                list_dist  = recv ? dist_in : '0;
                if (all_rcvd) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (rd_capture) begin
                    list_sel = rd_cnt[SEL_W-1:0];
                end
                if (rd_cnt == RD_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
